// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl_if
//  Purpose  : Bundle between the pipeline datapath and the hazard/control
//             unit. The datapath reports stage state and drives the `master`
//             side; the hazard unit drives forward selects, stalls and
//             flushes on the `slave` side.
//  Macro    : COTM32_HAZARD_PERF_EN adds the two 32-bit perf counter outputs
//  Revision : 1.0  initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5
);
  // Stage valid bits
  logic                      i_id_valid;
  logic                      i_ex_valid;
  logic                      i_mem_valid;
  logic                      i_wb_valid;
  // ID stage sources
  logic [REG_ADDR_WIDTH-1:0] i_id_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] i_id_rs2_addr;
  logic                      i_id_uses_rs1;
  logic                      i_id_uses_rs2;
  // EX stage
  logic [REG_ADDR_WIDTH-1:0] i_ex_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] i_ex_rs2_addr;
  logic [REG_ADDR_WIDTH-1:0] i_ex_rd_addr;
  logic                      i_ex_regfile_we;
  logic                      i_ex_is_load;
  // MEM stage
  logic [REG_ADDR_WIDTH-1:0] i_mem_rd_addr;
  logic                      i_mem_regfile_we;
  logic                      i_mem_is_load;
  logic                      i_mem_access;
  // WB stage
  logic [REG_ADDR_WIDTH-1:0] i_wb_rd_addr;
  logic                      i_wb_regfile_we;
  // Redirect sources
  logic                      i_take_branch;
  logic                      i_trap_req;
  logic                      i_trap_mret;
  // Control outputs
  logic [1:0]                o_forward_a;
  logic [1:0]                o_forward_b;
  logic                      o_pc_stall;
  logic                      o_ifid_stall;
  logic                      o_ifid_flush;
  logic                      o_idex_stall;
  logic                      o_idex_flush;
  logic                      o_exmem_stall;
  logic                      o_exmem_flush;
  logic                      o_memwb_stall;
  logic                      o_memwb_flush;
  logic                      o_mem_busy;
`ifdef COTM32_HAZARD_PERF_EN
  logic [31:0]               o_perf_stall_cycles;
  logic [31:0]               o_perf_flush_events;
`endif

  // Hazard unit side
  modport slave (
    input  i_id_valid, i_ex_valid, i_mem_valid, i_wb_valid,
    input  i_id_rs1_addr, i_id_rs2_addr, i_id_uses_rs1, i_id_uses_rs2,
    input  i_ex_rs1_addr, i_ex_rs2_addr, i_ex_rd_addr, i_ex_regfile_we, i_ex_is_load,
    input  i_mem_rd_addr, i_mem_regfile_we, i_mem_is_load, i_mem_access,
    input  i_wb_rd_addr, i_wb_regfile_we,
    input  i_take_branch, i_trap_req, i_trap_mret,
    output o_forward_a, o_forward_b, o_pc_stall,
    output o_ifid_stall, o_ifid_flush, o_idex_stall, o_idex_flush,
    output o_exmem_stall, o_exmem_flush, o_memwb_stall, o_memwb_flush,
    output o_mem_busy
`ifdef COTM32_HAZARD_PERF_EN
    , output o_perf_stall_cycles, o_perf_flush_events
`endif
  );

  // Pipeline datapath side
  modport master (
    output i_id_valid, i_ex_valid, i_mem_valid, i_wb_valid,
    output i_id_rs1_addr, i_id_rs2_addr, i_id_uses_rs1, i_id_uses_rs2,
    output i_ex_rs1_addr, i_ex_rs2_addr, i_ex_rd_addr, i_ex_regfile_we, i_ex_is_load,
    output i_mem_rd_addr, i_mem_regfile_we, i_mem_is_load, i_mem_access,
    output i_wb_rd_addr, i_wb_regfile_we,
    output i_take_branch, i_trap_req, i_trap_mret,
    input  o_forward_a, o_forward_b, o_pc_stall,
    input  o_ifid_stall, o_ifid_flush, o_idex_stall, o_idex_flush,
    input  o_exmem_stall, o_exmem_flush, o_memwb_stall, o_memwb_flush,
    input  o_mem_busy
`ifdef COTM32_HAZARD_PERF_EN
    , input o_perf_stall_cycles, o_perf_flush_events
`endif
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Hazard and pipeline-control unit for the five-stage core:
//             operand forwarding, load-use interlock, multi-cycle DMEM wait
//             sequencer and a single priority scheme for every stall/flush.
//  Macro    : COTM32_HAZARD_PERF_EN enables stall-cycle / flush-event counters
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_LATENCY    = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  pipe_hazard_ctrl_if.slave  hz
);

  localparam int                  c_CNT_W     = $clog2(MEM_LATENCY + 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_LOAD  = c_CNT_W'(MEM_LATENCY - 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0]  c_CNT_ZERO  = '0;
  localparam logic                c_WAIT_EN   = (MEM_LATENCY > 1);
  localparam logic [REG_ADDR_WIDTH-1:0] c_X0  = '0;

  // forward_src_t encoding
  localparam logic [1:0] c_FWD_NONE  = 2'd0;
  localparam logic [1:0] c_FWD_EXMEM = 2'd1;
  localparam logic [1:0] c_FWD_MEMWB = 2'd2;

  // Wait sequencer states
  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_WAIT = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;

  logic       w_redirect;
  logic       w_wait_entry;
  logic       w_mem_wait;
  logic       w_mem_busy;
  logic       w_exmem_ok;
  logic       w_memwb_ok;
  logic       w_load_use;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  assign w_redirect   = hz.i_trap_req | hz.i_trap_mret;
  assign w_wait_entry = hz.i_mem_valid & hz.i_mem_access & c_WAIT_EN;

  // A load in MEM has no data yet, so it never forwards from EXMEM
  assign w_exmem_ok = hz.i_mem_valid & hz.i_mem_regfile_we & ~hz.i_mem_is_load &
                      (hz.i_mem_rd_addr != c_X0);
  assign w_memwb_ok = hz.i_wb_valid & hz.i_wb_regfile_we & (hz.i_wb_rd_addr != c_X0);

  // Forward select per EX operand; the younger EXMEM result wins over MEMWB
  always_comb begin
    w_fwd_a = c_FWD_NONE;
    w_fwd_b = c_FWD_NONE;
    if (w_exmem_ok && (hz.i_mem_rd_addr == hz.i_ex_rs1_addr))     w_fwd_a = c_FWD_EXMEM;
    else if (w_memwb_ok && (hz.i_wb_rd_addr == hz.i_ex_rs1_addr)) w_fwd_a = c_FWD_MEMWB;
    if (w_exmem_ok && (hz.i_mem_rd_addr == hz.i_ex_rs2_addr))     w_fwd_b = c_FWD_EXMEM;
    else if (w_memwb_ok && (hz.i_wb_rd_addr == hz.i_ex_rs2_addr)) w_fwd_b = c_FWD_MEMWB;
  end

  // Load in EX whose destination is read by the instruction in ID
  assign w_load_use = hz.i_ex_valid & hz.i_ex_is_load & hz.i_ex_regfile_we &
                      (hz.i_ex_rd_addr != c_X0) & hz.i_id_valid &
                      ((hz.i_id_uses_rs1 & (hz.i_id_rs1_addr == hz.i_ex_rd_addr)) |
                       (hz.i_id_uses_rs2 & (hz.i_id_rs2_addr == hz.i_ex_rd_addr)));

  // Wait sequencer state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= c_ST_IDLE;
      cnt_q   <= c_CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Wait sequencer next state; a trap/mret aborts any wait in progress
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (w_redirect) begin
      state_d = c_ST_IDLE;
      cnt_d   = c_CNT_ZERO;
    end else begin
      case (state_q)
        c_ST_IDLE: begin
          if (w_wait_entry) begin
            state_d = c_ST_WAIT;
            cnt_d   = c_CNT_LOAD;
          end
        end
        c_ST_WAIT: begin
          cnt_d = cnt_q - c_CNT_ONE;
          if (cnt_q == c_CNT_ONE) state_d = c_ST_IDLE;
        end
        default: begin
          state_d = c_ST_IDLE;
          cnt_d   = c_CNT_ZERO;
        end
      endcase
    end
  end

  // Wait sequencer outputs; the last WAIT cycle (cnt == 1) lets the pipe advance
  always_comb begin
    w_mem_wait = 1'b0;
    w_mem_busy = 1'b0;
    case (state_q)
      c_ST_IDLE: w_mem_wait = w_wait_entry;
      c_ST_WAIT: begin
        w_mem_wait = (cnt_q > c_CNT_ONE);
        w_mem_busy = 1'b1;
      end
      default: ;
    endcase
  end

  // Priority resolution: redirect > memory wait > branch > load-use
  always_comb begin
    hz.o_forward_a   = c_FWD_NONE;
    hz.o_forward_b   = c_FWD_NONE;
    hz.o_pc_stall    = 1'b0;
    hz.o_ifid_stall  = 1'b0;
    hz.o_ifid_flush  = 1'b0;
    hz.o_idex_stall  = 1'b0;
    hz.o_idex_flush  = 1'b0;
    hz.o_exmem_stall = 1'b0;
    hz.o_exmem_flush = 1'b0;
    hz.o_memwb_stall = 1'b0;
    hz.o_memwb_flush = 1'b0;
    hz.o_mem_busy    = 1'b0;
    if (!i_rst) begin
      hz.o_forward_a = w_fwd_a;
      hz.o_forward_b = w_fwd_b;
      hz.o_mem_busy  = w_mem_busy;
      if (w_redirect) begin
        hz.o_ifid_flush  = 1'b1;
        hz.o_idex_flush  = 1'b1;
        hz.o_exmem_flush = 1'b1;
      end else if (w_mem_wait) begin
        // EX is held too, so a pending branch/load-use re-evaluates on release
        hz.o_pc_stall    = 1'b1;
        hz.o_ifid_stall  = 1'b1;
        hz.o_idex_stall  = 1'b1;
        hz.o_exmem_stall = 1'b1;
        hz.o_memwb_flush = 1'b1;
      end else if (hz.i_take_branch) begin
        hz.o_ifid_flush  = 1'b1;
        hz.o_idex_flush  = 1'b1;
      end else if (w_load_use) begin
        hz.o_pc_stall    = 1'b1;
        hz.o_ifid_stall  = 1'b1;
        hz.o_idex_flush  = 1'b1;
      end
    end
  end

`ifdef COTM32_HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Counter increments, wrapping naturally at 2^32
  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, hz.o_pc_stall};
    perf_flush_d = perf_flush_q + {31'd0, hz.o_ifid_flush};
  end

  // Perf counter registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign hz.o_perf_stall_cycles = perf_stall_q;
  assign hz.o_perf_flush_events = perf_flush_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Directed scoreboard bench for pipe_hazard_ctrl (MEM_LATENCY=4).
//             Driver pushes hand-computed expectations; monitor compares on
//             each falling edge.
//  Macro    : COTM32_HAZARD_PERF_EN also checks the perf counters
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  // Control vector bit positions
  localparam logic [9:0] B_PC   = 10'b10_0000_0000;
  localparam logic [9:0] B_IFS  = 10'b01_0000_0000;
  localparam logic [9:0] B_IFF  = 10'b00_1000_0000;
  localparam logic [9:0] B_IDS  = 10'b00_0100_0000;
  localparam logic [9:0] B_IDF  = 10'b00_0010_0000;
  localparam logic [9:0] B_EMS  = 10'b00_0001_0000;
  localparam logic [9:0] B_EMF  = 10'b00_0000_1000;
  localparam logic [9:0] B_MWS  = 10'b00_0000_0100;
  localparam logic [9:0] B_MWF  = 10'b00_0000_0010;
  localparam logic [9:0] B_BUSY = 10'b00_0000_0001;

  localparam logic [9:0] C_NONE = 10'd0;
  localparam logic [9:0] C_LU   = B_PC | B_IFS | B_IDF;
  localparam logic [9:0] C_BR   = B_IFF | B_IDF;
  localparam logic [9:0] C_TRAP = B_IFF | B_IDF | B_EMF;
  localparam logic [9:0] C_WAIT = B_PC | B_IFS | B_IDS | B_EMS | B_MWF;

  typedef struct {
    string      name;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [9:0] ctl;
    logic [31:0] ps;
    logic [31:0] pf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;

  pipe_hazard_ctrl_if #(.REG_ADDR_WIDTH(5)) hz_if ();

  pipe_hazard_ctrl #(
    .REG_ADDR_WIDTH (5),
    .MEM_LATENCY    (4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .hz    (hz_if.slave)
  );

  always #5 clk = ~clk;

  task automatic clr();
    hz_if.i_id_valid = 0; hz_if.i_ex_valid = 0; hz_if.i_mem_valid = 0; hz_if.i_wb_valid = 0;
    hz_if.i_id_rs1_addr = 0; hz_if.i_id_rs2_addr = 0; hz_if.i_id_uses_rs1 = 0; hz_if.i_id_uses_rs2 = 0;
    hz_if.i_ex_rs1_addr = 0; hz_if.i_ex_rs2_addr = 0; hz_if.i_ex_rd_addr = 0;
    hz_if.i_ex_regfile_we = 0; hz_if.i_ex_is_load = 0;
    hz_if.i_mem_rd_addr = 0; hz_if.i_mem_regfile_we = 0; hz_if.i_mem_is_load = 0; hz_if.i_mem_access = 0;
    hz_if.i_wb_rd_addr = 0; hz_if.i_wb_regfile_we = 0;
    hz_if.i_take_branch = 0; hz_if.i_trap_req = 0; hz_if.i_trap_mret = 0;
  endtask

  // Push the expectation for the inputs just driven, then advance one cycle.
  // Perf counters show the count of earlier cycles (registered).
  task automatic issue(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [9:0] ctl);
    exp_t e;
    e.name = nm; e.fa = fa; e.fb = fb; e.ctl = ctl;
    if (rst) begin
      m_stall = 0; m_flush = 0;
      e.ps = 0; e.pf = 0;
    end else begin
      e.ps = m_stall; e.pf = m_flush;
      m_stall = m_stall + {31'd0, ctl[9]};
      m_flush = m_flush + {31'd0, ctl[7]};
    end
    sb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Monitor: compare DUT outputs against the oldest expectation
  initial begin
    exp_t e;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        act = {hz_if.o_pc_stall, hz_if.o_ifid_stall, hz_if.o_ifid_flush, hz_if.o_idex_stall,
               hz_if.o_idex_flush, hz_if.o_exmem_stall, hz_if.o_exmem_flush,
               hz_if.o_memwb_stall, hz_if.o_memwb_flush, hz_if.o_mem_busy};
        n_vec++;
`ifdef COTM32_HAZARD_PERF_EN
        if (act !== e.ctl || hz_if.o_forward_a !== e.fa || hz_if.o_forward_b !== e.fb ||
            hz_if.o_perf_stall_cycles !== e.ps || hz_if.o_perf_flush_events !== e.pf) begin
          n_err++;
          $display("FAIL %s: got fa=%0d fb=%0d ctl=%b ps=%0d pf=%0d, want fa=%0d fb=%0d ctl=%b ps=%0d pf=%0d",
                   e.name, hz_if.o_forward_a, hz_if.o_forward_b, act,
                   hz_if.o_perf_stall_cycles, hz_if.o_perf_flush_events,
                   e.fa, e.fb, e.ctl, e.ps, e.pf);
        end
`else
        if (act !== e.ctl || hz_if.o_forward_a !== e.fa || hz_if.o_forward_b !== e.fb) begin
          n_err++;
          $display("FAIL %s: got fa=%0d fb=%0d ctl=%b, want fa=%0d fb=%0d ctl=%b",
                   e.name, hz_if.o_forward_a, hz_if.o_forward_b, act, e.fa, e.fb, e.ctl);
        end
`endif
      end
    end
  end

  // Global time bound
  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish within 50000 time units");
    $fatal(1, "timeout");
  end

  // Driver: directed vectors
  initial begin
    clr();
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset: outputs forced to 0 despite active hazards
    hz_if.i_mem_valid = 1; hz_if.i_mem_regfile_we = 1; hz_if.i_mem_rd_addr = 5; hz_if.i_ex_rs1_addr = 5;
    hz_if.i_take_branch = 1; hz_if.i_mem_access = 1;
    issue("reset", 2'd0, 2'd0, C_NONE);
    rst = 1'b0; clr();
    issue("idle", 2'd0, 2'd0, C_NONE);

    // Forwarding
    hz_if.i_mem_valid = 1; hz_if.i_mem_regfile_we = 1; hz_if.i_mem_rd_addr = 5;
    hz_if.i_ex_rs1_addr = 5; hz_if.i_ex_rs2_addr = 1;
    issue("fwd_exmem", 2'd1, 2'd0, C_NONE);
    hz_if.i_wb_valid = 1; hz_if.i_wb_regfile_we = 1; hz_if.i_wb_rd_addr = 5;
    issue("fwd_exmem_over_memwb", 2'd1, 2'd0, C_NONE);
    hz_if.i_mem_rd_addr = 0; hz_if.i_wb_rd_addr = 0; hz_if.i_ex_rs1_addr = 0;
    issue("fwd_x0", 2'd0, 2'd0, C_NONE);
    clr();
    hz_if.i_wb_valid = 1; hz_if.i_wb_regfile_we = 1; hz_if.i_wb_rd_addr = 6;
    hz_if.i_ex_rs1_addr = 3; hz_if.i_ex_rs2_addr = 6;
    issue("fwd_memwb_b", 2'd0, 2'd2, C_NONE);
    clr();
    hz_if.i_mem_valid = 1; hz_if.i_mem_regfile_we = 1; hz_if.i_mem_is_load = 1; hz_if.i_mem_rd_addr = 7;
    hz_if.i_wb_valid = 1; hz_if.i_wb_regfile_we = 1; hz_if.i_wb_rd_addr = 7;
    hz_if.i_ex_rs1_addr = 7; hz_if.i_ex_rs2_addr = 7;
    issue("fwd_load_not_exmem", 2'd2, 2'd2, C_NONE);

    // Load-use
    clr();
    hz_if.i_ex_valid = 1; hz_if.i_ex_is_load = 1; hz_if.i_ex_regfile_we = 1; hz_if.i_ex_rd_addr = 7;
    hz_if.i_id_valid = 1; hz_if.i_id_rs1_addr = 7; hz_if.i_id_rs2_addr = 7;
    hz_if.i_id_uses_rs1 = 1; hz_if.i_id_uses_rs2 = 1;
    issue("load_use", 2'd0, 2'd0, C_LU);
    hz_if.i_id_uses_rs1 = 0; hz_if.i_id_uses_rs2 = 0;
    issue("load_use_unused_src", 2'd0, 2'd0, C_NONE);
    hz_if.i_id_uses_rs1 = 1; hz_if.i_ex_rd_addr = 0; hz_if.i_id_rs1_addr = 0;
    issue("load_use_x0", 2'd0, 2'd0, C_NONE);
    hz_if.i_ex_rd_addr = 9; hz_if.i_id_rs1_addr = 2; hz_if.i_id_rs2_addr = 9;
    hz_if.i_id_uses_rs1 = 0; hz_if.i_id_uses_rs2 = 1;
    issue("load_use_rs2", 2'd0, 2'd0, C_LU);

    // Branch, and branch beating load-use
    clr();
    hz_if.i_take_branch = 1;
    issue("branch", 2'd0, 2'd0, C_BR);
    hz_if.i_ex_valid = 1; hz_if.i_ex_is_load = 1; hz_if.i_ex_regfile_we = 1; hz_if.i_ex_rd_addr = 4;
    hz_if.i_id_valid = 1; hz_if.i_id_rs1_addr = 4; hz_if.i_id_uses_rs1 = 1;
    issue("branch_over_load_use", 2'd0, 2'd0, C_BR);

    // Store in MEM, latency 4: three stall cycles, busy on cycles 2..4
    clr();
    hz_if.i_mem_valid = 1; hz_if.i_mem_access = 1;
    issue("wait_c1", 2'd0, 2'd0, C_WAIT);
    issue("wait_c2", 2'd0, 2'd0, C_WAIT | B_BUSY);
    issue("wait_c3", 2'd0, 2'd0, C_WAIT | B_BUSY);
    issue("wait_c4_release", 2'd0, 2'd0, B_BUSY);

    // Back-to-back access with a branch pending throughout
    hz_if.i_take_branch = 1;
    issue("b2b_c1_branch_held", 2'd0, 2'd0, C_WAIT);
    issue("b2b_c2_branch_held", 2'd0, 2'd0, C_WAIT | B_BUSY);
    issue("b2b_c3_branch_held", 2'd0, 2'd0, C_WAIT | B_BUSY);
    issue("b2b_c4_branch_release", 2'd0, 2'd0, C_BR | B_BUSY);
    clr();
    issue("after_b2b_idle", 2'd0, 2'd0, C_NONE);

    // Trap on the second wait cycle aborts the wait
    hz_if.i_mem_valid = 1; hz_if.i_mem_access = 1;
    issue("trap_wait_c1", 2'd0, 2'd0, C_WAIT);
    hz_if.i_trap_req = 1;
    issue("trap_wait_c2", 2'd0, 2'd0, C_TRAP | B_BUSY);
    clr();
    issue("trap_after_idle", 2'd0, 2'd0, C_NONE);

    // mret outranks branch and load-use
    hz_if.i_trap_mret = 1; hz_if.i_take_branch = 1;
    hz_if.i_ex_valid = 1; hz_if.i_ex_is_load = 1; hz_if.i_ex_regfile_we = 1; hz_if.i_ex_rd_addr = 3;
    hz_if.i_id_valid = 1; hz_if.i_id_rs1_addr = 3; hz_if.i_id_uses_rs1 = 1;
    issue("mret_priority", 2'd0, 2'd0, C_TRAP);

    // Reset mid-wait aborts immediately
    clr();
    hz_if.i_mem_valid = 1; hz_if.i_mem_access = 1;
    issue("rst_wait_c1", 2'd0, 2'd0, C_WAIT);
    rst = 1'b1;
    issue("rst_wait_asserted", 2'd0, 2'd0, C_NONE);
    rst = 1'b0; clr();
    issue("rst_wait_after", 2'd0, 2'd0, C_NONE);

    // One load-use then one branch after a fresh reset
    hz_if.i_ex_valid = 1; hz_if.i_ex_is_load = 1; hz_if.i_ex_regfile_we = 1; hz_if.i_ex_rd_addr = 8;
    hz_if.i_id_valid = 1; hz_if.i_id_rs2_addr = 8; hz_if.i_id_uses_rs2 = 1;
    issue("perf_load_use", 2'd0, 2'd0, C_LU);
    clr();
    hz_if.i_take_branch = 1;
    issue("perf_branch", 2'd0, 2'd0, C_BR);
    clr();
    issue("perf_final", 2'd0, 2'd0, C_NONE);

    @(negedge clk); #1;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and pipeline-control unit for the five-stage core. It replaces the fixed two-source forwarding unit and generates every stage's stall and flush signal, plus PC hold, from a single priority scheme. It adds a load-use interlock and a multi-cycle data-memory wait sequencer, so DMEM can take `MEM_LATENCY` cycles. It sits in the PIPE section of `processor_core` and drives the `i_stall`/`i_flush` ports of `ifid_reg`, `idex_reg`, `exmem_reg` and `memwb_reg`, plus the forward muxes.

## Interface
Parameters:
- `REG_ADDR_WIDTH`, 5, register address width.
- `MEM_LATENCY`, 1, cycles a load/store occupies MEM (≥1; 1 means no wait).

Ports:
- `i_clk`  in  1  core clock
- `i_rst`  in  1  asynchronous, active-high reset
- `i_id_valid`, `i_ex_valid`, `i_mem_valid`, `i_wb_valid`  in  1 each  stage valid bits
- `i_id_rs1_addr`, `i_id_rs2_addr`  in  REG_ADDR_WIDTH  ID source registers
- `i_id_uses_rs1`, `i_id_uses_rs2`  in  1  ID instruction actually reads rs1/rs2
- `i_ex_rs1_addr`, `i_ex_rs2_addr`, `i_ex_rd_addr`  in  REG_ADDR_WIDTH  EX register addresses
- `i_ex_regfile_we`, `i_ex_is_load`  in  1  EX writes rd / is a load
- `i_mem_rd_addr`  in  REG_ADDR_WIDTH; `i_mem_regfile_we`, `i_mem_is_load`, `i_mem_access`  in  1  MEM destination, load flag, any DMEM/ROM access
- `i_wb_rd_addr`  in  REG_ADDR_WIDTH; `i_wb_regfile_we`  in  1
- `i_take_branch`, `i_trap_req`, `i_trap_mret`  in  1  redirect sources
- `o_forward_a`, `o_forward_b`  out  2  0 = none, 1 = EXMEM, 2 = MEMWB (the `forward_src_t` encoding)
- `o_pc_stall`  out  1
- `o_ifid_stall`, `o_ifid_flush`, `o_idex_stall`, `o_idex_flush`, `o_exmem_stall`, `o_exmem_flush`, `o_memwb_stall`, `o_memwb_flush`  out  1 each
- `o_mem_busy`  out  1  wait sequencer is in the WAIT state
- `o_perf_stall_cycles`, `o_perf_flush_events`  out  32  present only with `COTM32_HAZARD_PERF_EN`

## Operation
- **Forwarding (per operand):**
  - Select EXMEM when `i_mem_valid`, `i_mem_regfile_we`, `!i_mem_is_load`, `rd != 0` and rd matches the source.
  - Otherwise select MEMWB when `i_wb_valid`, `i_wb_regfile_we`, `rd != 0` and rd matches.
  - Otherwise select none. EXMEM has priority over MEMWB.
- **Load-use:** asserted when `i_ex_valid & i_ex_is_load & i_ex_regfile_we & i_ex_rd_addr != 0 & i_id_valid` and either (`i_id_uses_rs1` and rs1 matches) or (`i_id_uses_rs2` and rs2 matches).
- **Wait FSM** (states IDLE and WAIT; down-counter `cnt` of width `$clog2(MEM_LATENCY+1)`):
  - IDLE to WAIT when `i_mem_valid & i_mem_access & MEM_LATENCY > 1`; load `cnt = MEM_LATENCY-1`.
  - In WAIT, `cnt` decrements each cycle. When `cnt == 1`, return to IDLE.
  - `mem_wait = (IDLE & entry condition) | (WAIT & cnt > 1)`.
  - In the final WAIT cycle, with `cnt == 1`, `mem_wait` is 0 and the pipeline advances. A new access arriving on the next cycle re-enters WAIT.
- **Per-cycle priority**, highest first. All outputs not listed are 0.
  1. Trap or mret: flush IFID, IDEX and EXMEM. FSM is forced to IDLE and `cnt` to 0 next cycle, which aborts any wait.
  2. `mem_wait`: stall PC, IFID, IDEX and EXMEM; flush MEMWB (bubble). `i_take_branch` and load-use are ignored, because the EX instruction is held and re-evaluates after release.
  3. `i_take_branch`: flush IFID and IDEX.
  4. Load-use: stall PC and IFID; flush IDEX (one bubble).
- `o_memwb_stall` is always 0.
- `i_take_branch & i_ex_is_load` together is illegal upstream; if it occurs, rule 3 wins.

## Timing
- Forwarding, stall and flush outputs are combinational from inputs and state, with zero latency.
- While `i_rst` is high, all outputs are 0, the state is IDLE, `cnt` is 0 and the perf counters are 0. Reset asserted mid-wait aborts immediately.
- A load-use stall lasts exactly 1 cycle.
- A memory access holds the pipeline `MEM_LATENCY-1` cycles and occupies MEM for `MEM_LATENCY` cycles.
- With `MEM_LATENCY == 1` the FSM never leaves IDLE and `o_mem_busy` stays 0.
- Back-to-back accesses each incur the full `MEM_LATENCY-1` stall cycles.

## Configuration
- `COTM32_HAZARD_PERF_EN` defined:
  - `o_perf_stall_cycles` increments on every cycle with `o_pc_stall == 1`.
  - `o_perf_flush_events` increments on every cycle with `o_ifid_flush == 1`.
  - Both are 32 bits, wrap modulo 2^32 and reset to 0.
- Not defined: both ports and counters are absent, with no other behavioural difference.

## Test plan
- EX `add x5` in MEM and `sub x6, x5, x1` in EX: `o_forward_a = 1`. Same rd also in WB: still 1. rd = x0: `o_forward_a = 0`.
- `lw x7` in EX and `add x8, x7, x7` in ID: one cycle of `o_pc_stall = o_ifid_stall = o_idex_flush = 1`. Next cycle, with the load in MEM/WB, `o_forward_a = o_forward_b = 2`.
- `MEM_LATENCY = 4`, store in MEM: stalls on 3 consecutive cycles, `o_memwb_flush = 1` on those cycles, `o_mem_busy` high for cycles 2–4, pipeline advances on cycle 4.
- `MEM_LATENCY = 4`, `i_trap_req` on the 2nd wait cycle: IFID, IDEX and EXMEM flush; no stall; state IDLE on the next cycle.
- `i_take_branch` asserted during a wait: no flush until the release cycle, when `o_ifid_flush = o_idex_flush = 1`.
- With `COTM32_HAZARD_PERF_EN`: after one load-use stall and one branch, `o_perf_stall_cycles = 1` and `o_perf_flush_events = 1`. Reset clears both to 0.
